uart_cfg: RTL and testbench
===========================

UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..8).
REQ-002 SHALL have parameter DIV_W, default 16, width of the clk_div port.
REQ-003 SHALL have parameter TXF_DEPTH, default 4, TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port clk_div  in  DIV_W  clocks per bit; values <4 treated as 4.
REQ-007 SHALL have port two_stop  in  1  TX sends 2 stop bits when 1, else 1.
REQ-008 SHALL have port parity_en  in  1  parity bit enable.
REQ-009 SHALL have port parity_odd  in  1  odd parity when 1, else even.
REQ-010 SHALL have port tx_data  in  DATA_BITS  byte to transmit.
REQ-011 SHALL have port tx_valid  in  1  push request.
REQ-012 SHALL have port tx_ready  out  1  FIFO not full.
REQ-013 SHALL have port tx  out  1  serial output, idle high.
REQ-014 SHALL have port tx_busy  out  1  frame in flight or FIFO non-empty.
REQ-015 SHALL have port rx  in  1  asynchronous serial input.
REQ-016 SHALL have port rx_data  out  DATA_BITS  last received word.
REQ-017 SHALL have port rx_valid  out  1  one-cycle pulse, new rx_data.
REQ-018 SHALL have port rx_frame_err  out  1  stop bit sampled 0; valid with rx_valid.
REQ-019 SHALL have port rx_parity_err  out  1  parity mismatch; valid with rx_valid.

Function
REQ-020 SHALL push tx_data into the FIFO when tx_valid && tx_ready; pushes while full are dropped; simultaneous push and pop both take effect.
REQ-021 SHALL use TX states IDLE, START, DATA, PARITY, STOP; IDLE pops the FIFO when non-empty and latches clk_div, two_stop, parity_en, parity_odd for the whole frame.
REQ-022 SHALL drive tx low 2 cycles after the accepting push edge when idle with FIFO empty; every bit lasts exactly the latched clk_div cycles; data LSB first.
REQ-023 SHALL insert PARITY only when parity_en is latched; even parity makes data+parity ones count even.
REQ-024 SHALL hold tx high in IDLE; back-to-back frames have exactly one idle-high cycle between last stop bit and next start bit.
REQ-025 SHALL pass rx through a 2-flop synchroniser; all RX decisions use the synchronised value.
REQ-026 SHALL use RX states IDLE, START, DATA, PARITY, STOP, BREAK; IDLE latches clk_div and moves to START on synchronised low.
REQ-027 SHALL in START wait floor(clk_div/2) cycles, then re-sample: low -> DATA, high -> IDLE (glitch reject, no rx_valid).
REQ-028 SHALL sample each data, parity and first stop bit every clk_div cycles after the mid-start sample; RX checks one stop bit regardless of two_stop.
REQ-029 SHALL, on the stop sample, update rx_data and error flags and pulse rx_valid the next cycle; unread data is overwritten (no back-pressure).
REQ-030 SHALL go to IDLE after a good stop bit, to BREAK after a bad one; BREAK returns to IDLE only after synchronised rx is high.
REQ-031 SHALL ignore changes to clk_div or mode inputs mid-frame in both directions.

Reset
REQ-032 SHALL, on rst_n low at a clock edge: tx=1, tx_busy=0, tx_ready=1, FIFO empty, rx_data=0, rx_valid=0, both error flags 0, both FSMs IDLE, counters 0, synchroniser flops 1.
REQ-033 SHALL abort any frame in progress on reset; tx is high from the first edge with rst_n low.

Configuration
REQ-034 SHALL compile parity logic only when macro UART_CFG_PARITY_EN is defined.
REQ-035 SHALL, without UART_CFG_PARITY_EN, keep parity_en/parity_odd ports but ignore them, never emit or expect a parity bit, and tie rx_parity_err to 0.

Verification
REQ-036 SHALL cover: clk_div=10, 1 stop, no parity, push 0xA5 -> tx 0,1,0,1,0,0,1,0,1,1 each 10 cycles, then tx_busy=0.
REQ-037 SHALL cover (macro on): parity_en=1 even, push 0x07 -> parity bit 1; odd -> 0; loopback rx_parity_err=0.
REQ-038 SHALL cover: tx looped to rx, clk_div=10, push 0x3C -> single rx_valid with rx_data=0x3C, both error flags 0.
REQ-039 SHALL cover: rx low 3 cycles, clk_div=10 -> no rx_valid; rx stop bit forced 0 -> rx_valid=1, rx_frame_err=1, no new frame until rx high.
REQ-040 SHALL cover: TXF_DEPTH=4, tx_valid high 6 consecutive cycles from idle -> 5 accepted, tx_ready low on 6th, 5 frames out in order.
REQ-041 SHALL cover: rst_n low mid-DATA -> tx=1, FIFO empty, tx_busy=0 next edge; next push transmits cleanly.

Source files
------------

// File: rtl/uart_cfg.sv
// uart_cfg: configurable UART with a small TX FIFO, runtime-selectable bit
// period (clk_div), one or two TX stop bits and optional parity.
// Build option: define UART_CFG_PARITY_EN to compile in parity generation and
// checking; without it the parity ports are accepted but ignored and
// rx_parity_err is held at 0.
module uart_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16,
  parameter int TXF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic                 two_stop,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int AW = $clog2(TXF_DEPTH);
  localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(4);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  // ------------------------------------------------------------------
  // Mode inputs as seen by the framers (parity forced off when not built)
  // ------------------------------------------------------------------
  logic             par_en_cfg;
  logic             par_odd_cfg;
  logic             rx_perr_reg;
  logic [DIV_W-1:0] div_eff;

`ifdef UART_CFG_PARITY_EN
  assign par_en_cfg    = parity_en;
  assign par_odd_cfg   = parity_odd;
  assign rx_parity_err = rx_perr_reg;
`else
  assign par_en_cfg    = 1'b0;
  assign par_odd_cfg   = 1'b0;
  assign rx_parity_err = 1'b0;
  logic unused_parity;
  assign unused_parity = ^{parity_en, parity_odd, rx_perr_reg};
`endif

  // Bit periods shorter than 4 clocks leave no room for mid-bit sampling.
  assign div_eff = (clk_div < DIV_MIN) ? DIV_MIN : clk_div;

  // ------------------------------------------------------------------
  // TX FIFO (pointers carry one extra wrap bit to tell full from empty)
  // ------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem [TXF_DEPTH];
  logic [AW:0]          wr_ptr_reg;
  logic [AW:0]          rd_ptr_reg;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_push;
  logic                 tx_pop;
  logic [DATA_BITS-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_push  = tx_valid && !fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr_reg[AW-1:0]];
  assign tx_ready   = !fifo_full;

  // FIFO pointer update; push and pop in the same cycle both apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (tx_pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && fifo_push) fifo_mem[wr_ptr_reg[AW-1:0]] <= tx_data;
  end

  // ------------------------------------------------------------------
  // TX framer
  // ------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  tx_state_t            tx_state_reg, tx_state_next;
  logic [DIV_W-1:0]     tx_cnt_reg, tx_cnt_next;
  logic [DIV_W-1:0]     tx_div_reg, tx_div_next;
  logic [2:0]           tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tx_two_reg, tx_two_next;
  logic                 tx_par_en_reg, tx_par_en_next;
  logic                 tx_par_bit_reg, tx_par_bit_next;
  logic                 tx_stop2_reg, tx_stop2_next;
  logic                 tx_out_reg;
  logic                 tx_frame_reg;
  logic                 tx_line;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_reg == tx_div_reg - DIV_ONE);

  // TX next-state logic; config is captured at pop and held for the frame.
  always_comb begin
    tx_state_next   = tx_state_reg;
    tx_cnt_next     = tx_bit_end ? '0 : tx_cnt_reg + DIV_ONE;
    tx_div_next     = tx_div_reg;
    tx_bit_next     = tx_bit_reg;
    tx_shift_next   = tx_shift_reg;
    tx_two_next     = tx_two_reg;
    tx_par_en_next  = tx_par_en_reg;
    tx_par_bit_next = tx_par_bit_reg;
    tx_stop2_next   = tx_stop2_reg;
    tx_pop          = 1'b0;
    tx_line         = 1'b1;
    case (tx_state_reg)
      TX_IDLE: begin
        tx_cnt_next = '0;
        if (!fifo_empty) begin
          tx_pop          = 1'b1;
          tx_state_next   = TX_START;
          tx_div_next     = div_eff;
          tx_two_next     = two_stop;
          tx_par_en_next  = par_en_cfg;
          tx_par_bit_next = (^fifo_head) ^ par_odd_cfg;
          tx_shift_next   = fifo_head;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) begin
          tx_state_next = TX_DATA;
          tx_bit_next   = '0;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift_reg[0];
        if (tx_bit_end) begin
          tx_shift_next = tx_shift_reg >> 1;
          tx_stop2_next = 1'b0;
          if (tx_bit_reg == LAST_BIT) begin
            tx_state_next = tx_par_en_reg ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        tx_line = tx_par_bit_reg;
        if (tx_bit_end) tx_state_next = TX_STOP;
      end
      TX_STOP: begin
        tx_line = 1'b1;
        if (tx_bit_end) begin
          if (tx_two_reg && !tx_stop2_reg) tx_stop2_next = 1'b1;
          else                             tx_state_next = TX_IDLE;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // TX state register; the line is re-timed one cycle behind the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_reg   <= TX_IDLE;
      tx_cnt_reg     <= '0;
      tx_div_reg     <= '0;
      tx_bit_reg     <= '0;
      tx_shift_reg   <= '0;
      tx_two_reg     <= 1'b0;
      tx_par_en_reg  <= 1'b0;
      tx_par_bit_reg <= 1'b0;
      tx_stop2_reg   <= 1'b0;
      tx_out_reg     <= 1'b1;
      tx_frame_reg   <= 1'b0;
    end else begin
      tx_state_reg   <= tx_state_next;
      tx_cnt_reg     <= tx_cnt_next;
      tx_div_reg     <= tx_div_next;
      tx_bit_reg     <= tx_bit_next;
      tx_shift_reg   <= tx_shift_next;
      tx_two_reg     <= tx_two_next;
      tx_par_en_reg  <= tx_par_en_next;
      tx_par_bit_reg <= tx_par_bit_next;
      tx_stop2_reg   <= tx_stop2_next;
      tx_out_reg     <= tx_line;
      tx_frame_reg   <= (tx_state_reg != TX_IDLE);
    end
  end

  assign tx = tx_out_reg;
  // tx_frame_reg covers the final re-timed stop-bit cycle after the FSM idles.
  assign tx_busy = (tx_state_reg != TX_IDLE) || !fifo_empty || tx_frame_reg;

  // ------------------------------------------------------------------
  // RX synchroniser and deframer
  // ------------------------------------------------------------------
  logic rx_meta_reg;
  logic rx_sync_reg;

  // Two-flop synchroniser for the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_t;

  rx_state_t            rx_state_reg, rx_state_next;
  logic [DIV_W-1:0]     rx_cnt_reg, rx_cnt_next;
  logic [DIV_W-1:0]     rx_div_reg, rx_div_next;
  logic [2:0]           rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_par_en_reg, rx_par_en_next;
  logic                 rx_par_odd_reg, rx_par_odd_next;
  logic                 rx_pacc_reg, rx_pacc_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_next;
  logic                 rx_valid_reg;
  logic                 rx_ferr_reg, rx_ferr_next;
  logic                 rx_perr_next;
  logic                 rx_bit_end;
  logic                 rx_half_end;

  assign rx_bit_end  = (rx_cnt_reg == rx_div_reg - DIV_ONE);
  assign rx_half_end = (rx_cnt_reg == (rx_div_reg >> 1) - DIV_ONE);

  // RX next-state logic; samples land mid-bit, one period after mid-start.
  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_cnt_next     = rx_bit_end ? '0 : rx_cnt_reg + DIV_ONE;
    rx_div_next     = rx_div_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    rx_par_en_next  = rx_par_en_reg;
    rx_par_odd_next = rx_par_odd_reg;
    rx_pacc_next    = rx_pacc_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    rx_ferr_next    = rx_ferr_reg;
    rx_perr_next    = rx_perr_reg;
    case (rx_state_reg)
      RX_IDLE: begin
        rx_cnt_next = '0;
        if (!rx_sync_reg) begin
          rx_state_next   = RX_START;
          rx_div_next     = div_eff;
          rx_par_en_next  = par_en_cfg;
          rx_par_odd_next = par_odd_cfg;
          rx_pacc_next    = 1'b0;
        end
      end
      RX_START: begin
        rx_cnt_next = rx_cnt_reg + DIV_ONE;
        if (rx_half_end) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          // A start bit that has gone high again by mid-bit was a glitch.
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
          if (rx_bit_reg == LAST_BIT) begin
            rx_state_next = rx_par_en_reg ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 3'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_pacc_next  = rx_sync_reg ^ (^rx_shift_reg) ^ rx_par_odd_reg;
          rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          rx_data_next  = rx_shift_reg;
          rx_valid_next = 1'b1;
          rx_ferr_next  = !rx_sync_reg;
          rx_perr_next  = rx_pacc_reg;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        rx_cnt_next = '0;
        if (rx_sync_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // RX state and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_div_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_en_reg  <= 1'b0;
      rx_par_odd_reg <= 1'b0;
      rx_pacc_reg    <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_ferr_reg    <= 1'b0;
      rx_perr_reg    <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      rx_cnt_reg     <= rx_cnt_next;
      rx_div_reg     <= rx_div_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      rx_par_en_reg  <= rx_par_en_next;
      rx_par_odd_reg <= rx_par_odd_next;
      rx_pacc_reg    <= rx_pacc_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      rx_ferr_reg    <= rx_ferr_next;
      rx_perr_reg    <= rx_perr_next;
    end
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_frame_err = rx_ferr_reg;

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: directed checks of uart_cfg (TX framing, loopback RX, glitch
// and break handling, FIFO full behaviour, reset abort).
module tb_uart_cfg;

  logic        clk;
  logic        rst_n;
  logic [15:0] clk_div;
  logic        two_stop;
  logic        parity_en;
  logic        parity_odd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        tx_busy;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_frame_err;
  logic        rx_parity_err;

  logic        rx_drv;
  logic        loop_en;
  int          n_asserts;
  int          n_fail;
  logic [9:0]  rxq[$];

  assign rx = loop_en ? tx : rx_drv;

  uart_cfg #(.DATA_BITS(8), .DIV_W(16), .TXF_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .two_stop(two_stop),
    .parity_en(parity_en), .parity_odd(parity_odd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx(tx), .tx_busy(tx_busy), .rx(rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_frame_err(rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every received word as {frame_err, parity_err, data}.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxq.push_back({rx_frame_err, rx_parity_err, rx_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input int idx, input logic [9:0] exp);
    n_asserts++;
    assert (idx < rxq.size()) else begin
      n_fail++;
      $error("FAIL %s: observed %0d words expected more than %0d", tag, rxq.size(), idx);
    end
    if (idx < rxq.size()) chk(tag, 32'(rxq[idx]), 32'(exp));
  endtask

  task automatic push(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Called right after the push edge with the transmitter idle and FIFO
  // empty; checks tx on every cycle of the frame.
  task automatic check_tx_frame(input string tag, input logic [7:0] d, input int div,
                                input int nstop, input bit has_par, input bit par_bit,
                                input bit perturb);
    logic [11:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
    if (has_par) begin
      bits[nb] = par_bit;
      nb++;
    end
    nb += nstop;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("%s_lat%0d", tag, k), 32'(tx), 32'(1));
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clk);
        if (perturb && b == 3 && c == 0) begin
          clk_div  = 16'd7;
          two_stop = ~two_stop;
        end
        chk($sformatf("%s_bit%0d_c%0d", tag, b, c), 32'(tx), 32'(bits[b]));
      end
    end
    @(negedge clk);
    chk({tag, "_idle_tx"}, 32'(tx), 32'(1));
    chk({tag, "_idle_busy"}, 32'(tx_busy), 32'(0));
  endtask

  task automatic drive_rx_frame(input logic [7:0] d, input logic stop_val);
    rx_drv = 1'b0;
    repeat (10) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (10) @(posedge clk);
    end
    rx_drv = stop_val;
    repeat (10) @(posedge clk);
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    clk_div    = 16'd10;
    two_stop   = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    rx_drv     = 1'b1;
    loop_en    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(tx_busy), 32'(0));
    chk("rst_ready", 32'(tx_ready), 32'(1));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_ferr", 32'(rx_frame_err), 32'(0));
    chk("rst_perr", 32'(rx_parity_err), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, clk_div 10, 1 stop; config changes mid-frame must be ignored
    push(8'hA5);
    check_tx_frame("a5", 8'hA5, 10, 1, 1'b0, 1'b0, 1'b1);
    clk_div  = 16'd10;
    two_stop = 1'b0;
    repeat (3) @(negedge clk);

    // clk_div below minimum is clamped to 4; two stop bits
    clk_div  = 16'd2;
    two_stop = 1'b1;
    push(8'h01);
    check_tx_frame("div2_2stop", 8'h01, 4, 2, 1'b0, 1'b0, 1'b0);
    clk_div  = 16'd10;
    two_stop = 1'b0;
    repeat (3) @(negedge clk);

    // Loopback 0x3C
    loop_en = 1'b1;
    rxq.delete();
    push(8'h3C);
    repeat (140) @(negedge clk);
    chk("lb3c_count", 32'(rxq.size()), 32'(1));
    chk_rx("lb3c_word", 0, {2'b00, 8'h3C});

    // Parity: even then odd on 0x07 (ignored when parity is not built)
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    rxq.delete();
    push(8'h07);
`ifdef UART_CFG_PARITY_EN
    check_tx_frame("par_even", 8'h07, 10, 1, 1'b1, 1'b1, 1'b0);
`else
    check_tx_frame("par_even", 8'h07, 10, 1, 1'b0, 1'b0, 1'b0);
`endif
    repeat (20) @(negedge clk);
    chk("par_even_count", 32'(rxq.size()), 32'(1));
    chk_rx("par_even_word", 0, {2'b00, 8'h07});
    parity_odd = 1'b1;
    rxq.delete();
    push(8'h07);
`ifdef UART_CFG_PARITY_EN
    check_tx_frame("par_odd", 8'h07, 10, 1, 1'b1, 1'b0, 1'b0);
`else
    check_tx_frame("par_odd", 8'h07, 10, 1, 1'b0, 1'b0, 1'b0);
`endif
    repeat (20) @(negedge clk);
    chk("par_odd_count", 32'(rxq.size()), 32'(1));
    chk_rx("par_odd_word", 0, {2'b00, 8'h07});
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // 3-cycle low glitch on rx must not produce a word
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (5) @(posedge clk);
    rxq.delete();
    #1;
    rx_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", 32'(rxq.size()), 32'(0));

    // Stop bit forced low: framing error, then line held low (break)
    drive_rx_frame(8'hC3, 1'b0);
    repeat (150) @(posedge clk);
    chk("break_count", 32'(rxq.size()), 32'(1));
    chk_rx("break_word", 0, {2'b10, 8'hC3});
    rx_drv = 1'b1;
    repeat (5) @(posedge clk);
    drive_rx_frame(8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    chk("after_break_count", 32'(rxq.size()), 32'(2));
    chk_rx("after_break_word", 1, {2'b00, 8'h5A});

    // FIFO: tx_valid held for 6 cycles from idle, 5 accepted
    loop_en = 1'b1;
    rxq.delete();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_data  = 8'(8'h11 * (i + 1));
      tx_valid = 1'b1;
      chk($sformatf("fifo_ready%0d", i), 32'(tx_ready), 32'(i < 5));
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("fifo_busy", 32'(tx_busy), 32'(1));
    repeat (620) @(negedge clk);
    chk("fifo_count", 32'(rxq.size()), 32'(5));
    for (int i = 0; i < 5; i++)
      chk_rx($sformatf("fifo_word%0d", i), i, {2'b00, 8'(8'h11 * (i + 1))});
    chk("fifo_done_busy", 32'(tx_busy), 32'(0));

    // Reset mid-DATA aborts the frame and empties the FIFO
    rxq.delete();
    push(8'hF0);
    push(8'h0F);
    push(8'h33);
    repeat (40) @(negedge clk);
    chk("pre_rst_busy", 32'(tx_busy), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(tx), 32'(1));
    chk("mid_rst_busy", 32'(tx_busy), 32'(0));
    chk("mid_rst_ready", 32'(tx_ready), 32'(1));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_count", 32'(rxq.size()), 32'(0));
    chk("post_rst_busy", 32'(tx_busy), 32'(0));
    push(8'h96);
    repeat (140) @(negedge clk);
    chk("post_rst_frames", 32'(rxq.size()), 32'(1));
    chk_rx("post_rst_word", 0, {2'b00, 8'h96});
    chk("post_rst_idle", 32'(tx_busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
